// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-port synchronous memory between the
//               instruction-fetch port (i_*) and the load/store port (d_*).
//               Builds byte-lane write enables and lane-replicated write data
//               from the store width and the low address bits. Rejects
//               misaligned data accesses. Tracks one outstanding access
//               against a fixed read latency and routes the response back to
//               the requester that issued it.
// Macro       : XGRISCV_ARB_RR_EN - round-robin tie break between fetch and
//               data. When undefined, data always wins a tie.
// Parameters  : MEM_LAT - memory read latency in cycles (1..7)
// Ports       : clk, reset (async, active-low)
//               i_req/i_addr -> i_gnt, i_rvalid, i_rdata      fetch side
//               d_req/d_we/d_swhb/d_addr/d_wdata
//                 -> d_gnt, d_err, d_rvalid, d_rdata          data side
//               m_en, m_we, m_addr, m_wdata <- m_rdata        memory side
// Revision    : 1.0 - initial release
// ============================================================================
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ADDR_SIZE
`define ADDR_SIZE 32
`endif

module mem_port_arbiter #(
  parameter int MEM_LAT = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_req,
  input  logic [`ADDR_SIZE-1:0] i_addr,
  output logic                  i_gnt,
  output logic                  i_rvalid,
  output logic [`XLEN-1:0]      i_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [1:0]            d_swhb,
  input  logic [`ADDR_SIZE-1:0] d_addr,
  input  logic [`XLEN-1:0]      d_wdata,
  output logic                  d_gnt,
  output logic                  d_err,
  output logic                  d_rvalid,
  output logic [`XLEN-1:0]      d_rdata,
  output logic                  m_en,
  output logic [3:0]            m_we,
  output logic [`ADDR_SIZE-1:0] m_addr,
  output logic [`XLEN-1:0]      m_wdata,
  input  logic [`XLEN-1:0]      m_rdata
);

  localparam logic [2:0]            C_LAT        = 3'(MEM_LAT);
  localparam logic [`ADDR_SIZE-1:0] C_ALIGN_MASK = ~(`ADDR_SIZE'(3));

  logic [2:0] cnt_q, cnt_d;
  logic       src_q, src_d;   // 0 = fetch owns the pending response, 1 = data

  logic w_eligible;
  logic w_data_prio;
  logic w_data_win;
  logic w_fetch_win;
  logic w_misaligned;
  logic w_is_half;
  logic w_is_byte;

`ifdef XGRISCV_ARB_RR_EN
  logic last_q, last_d;       // 0 = fetch was granted last, 1 = data
  // On a tie the side that was not served last goes first.
  assign w_data_prio = ~last_q;
`else
  assign w_data_prio = 1'b1;
`endif

  // A new access may issue while the previous one is delivering (cnt==1),
  // which is what lets MEM_LAT=1 sustain one access per cycle.
  assign w_eligible   = (cnt_q <= 3'd1);
  assign w_is_half    = (d_swhb == 2'b10);
  assign w_is_byte    = (d_swhb == 2'b11);
  // 00 and 01 are both word accesses.
  assign w_misaligned = w_is_half ? d_addr[0] :
                        w_is_byte ? 1'b0 : (d_addr[1:0] != 2'b00);

  assign w_data_win  = w_eligible & d_req & (~i_req | w_data_prio);
  assign w_fetch_win = w_eligible & i_req & ~w_data_win;

  assign i_gnt = w_fetch_win;
  assign d_gnt = w_data_win;
  assign d_err = w_data_win & w_misaligned;

  // A rejected data access still consumes the grant slot, so fetch waits.
  assign m_en   = w_fetch_win | (w_data_win & ~w_misaligned);
  assign m_addr = (w_data_win ? d_addr : i_addr) & C_ALIGN_MASK;

  always_comb begin
    m_we    = 4'b0000;
    m_wdata = d_wdata;
    if (w_is_half) begin
      m_wdata = {2{d_wdata[15:0]}};
    end else if (w_is_byte) begin
      m_wdata = {4{d_wdata[7:0]}};
    end
    if (w_data_win && !w_misaligned && d_we) begin
      if (w_is_half) begin
        m_we = d_addr[1] ? 4'b1100 : 4'b0011;
      end else if (w_is_byte) begin
        m_we = 4'b0001 << d_addr[1:0];
      end else begin
        m_we = 4'b1111;
      end
    end
  end

  // Response is decoded purely from registered state.
  assign i_rvalid = (cnt_q == 3'd1) & ~src_q;
  assign d_rvalid = (cnt_q == 3'd1) &  src_q;
  assign i_rdata  = m_rdata;
  assign d_rdata  = m_rdata;

  always_comb begin
    cnt_d = cnt_q;
    src_d = src_q;
    if (m_en) begin
      cnt_d = C_LAT;
      src_d = w_data_win;
    end else if (cnt_q != 3'd0) begin
      cnt_d = cnt_q - 3'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= 3'd0;
      src_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      src_q <= src_d;
    end
  end

`ifdef XGRISCV_ARB_RR_EN
  always_comb begin
    last_d = last_q;
    if (w_data_win) begin
      last_d = 1'b1;
    end else if (w_fetch_win) begin
      last_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q <= 1'b0;
    end else begin
      last_q <= last_d;
    end
  end
`endif

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates one shared single-port synchronous memory between the instruction-fetch requester and the load/store requester of the xgriscv core. Byte-lane write enables and lane-replicated write data are generated from the store width and low address bits. Misaligned data accesses are rejected. The block tracks one outstanding access against a fixed memory read latency and returns the response to the requester that issued it.

## Interface
Parameters:
- MEM_LAT, 1: memory read latency in cycles, legal range 1..7.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- i_req  in  1  fetch request; i_addr held stable until granted.
- i_addr  in  `ADDR_SIZE  fetch byte address; low 2 bits ignored.
- i_gnt  out  1  fetch accepted this cycle.
- i_rvalid  out  1  fetch response valid.
- i_rdata  out  `XLEN  fetch word.
- d_req  in  1  data request; all d_* inputs held stable until granted.
- d_we  in  1  1 = store, 0 = load.
- d_swhb  in  2  width: 01 word, 10 half, 11 byte, 00 treated as word.
- d_addr  in  `ADDR_SIZE  data byte address.
- d_wdata  in  `XLEN  store data, right-aligned.
- d_gnt  out  1  data request accepted or rejected this cycle.
- d_err  out  1  misaligned access rejected this cycle.
- d_rvalid  out  1  data response valid; asserted for loads and stores.
- d_rdata  out  `XLEN  raw aligned word. Sign/zero extension is done in the datapath.
- m_en  out  1  memory access issued this cycle.
- m_we  out  4  byte write enables; 0000 for reads.
- m_addr  out  `ADDR_SIZE  word-aligned address ({addr[hi:2],2'b00}).
- m_wdata  out  `XLEN  lane-replicated store data.
- m_rdata  in  `XLEN  memory read data, valid MEM_LAT cycles after m_en.

## Operation
- State:
  - cnt: 3-bit outstanding counter.
  - src: 1-bit response owner (0 fetch, 1 data).
  - last: 1-bit last-granted requester.
- Issue-eligible cycle: cnt==0 or cnt==1.
- Winner selection in an eligible cycle with requests pending:
  - Default: data wins over fetch.
  - Under ARB_RR_EN: see Configuration.
- Grant cycle:
  - Assert gnt to the winner, plus m_en, m_addr, m_we, m_wdata.
  - Register src = winner, last = winner, cnt = MEM_LAT.
- Non-grant cycle: cnt decrements when nonzero.
- Response: in the cycle cnt==1, assert src's rvalid. That requester's rdata = m_rdata.
  - A new grant in that same cycle reloads cnt, so MEM_LAT=1 gives one access per cycle.
- Store lanes:
  - Word: m_we=1111, m_wdata=d_wdata.
  - Half: m_we=1100 if addr[1] else 0011; m_wdata={2{d_wdata[15:0]}}.
  - Byte: m_we=0001<<addr[1:0]; m_wdata={4{d_wdata[7:0]}}.
- Misaligned: word with addr[1:0]≠00, or half with addr[0]=1.
  - If the data side wins: d_gnt=1 and d_err=1 in the same cycle. No m_en, no counter load, no d_rvalid ever.
  - Fetch may not be granted in that cycle.
  - last updates to data.
- Idle outputs: m_en=0, m_we=0000, m_addr/m_wdata don't-care. Non-owner rvalid=0. Non-owner rdata don't-care.
- Reset (any time, including mid-access): cnt=0, src=0, last=0. The pending response is discarded and never signalled.

## Timing
- Reset values: i_gnt, d_gnt, d_err, i_rvalid, d_rvalid, m_en = 0; m_we = 0000.
- Combinational outputs (same cycle as request): gnt, err, m_*.
- rvalid is purely a function of registered cnt/src.
- Latency: request with no contention, granted cycle N → rvalid cycle N+MEM_LAT.
- Throughput: one access per MEM_LAT cycles. cnt∈{2..MEM_LAT} blocks all grants.
- Simultaneous i_req and d_req: exactly one gnt. The loser keeps its request and is granted no earlier than the next eligible cycle.
- Requests change only after gnt. Deasserting req before gnt is a protocol error with undefined behaviour.

## Configuration
- XGRISCV_ARB_RR_EN:
  - Defined: round-robin. On a tie the requester ≠ last wins, so neither side starves.
  - Undefined: fixed data priority, and last is unused (may be optimised away). Fetch waits as long as d_req is held in eligible cycles.

## Test plan
- MEM_LAT=1, i_req only, i_addr=0x0000_0104, m_rdata=0x0010_0093 → i_gnt cycle 0 with m_addr=0x104, m_we=0000; i_rvalid cycle 1 with i_rdata=0x0010_0093.
- Byte store, d_addr=0x...0003, d_wdata=0x0000_00AB → m_we=1000, m_wdata=0xABAB_ABAB, d_rvalid next cycle. Half store at 0x...0002, wdata 0x1234 → m_we=1100, m_wdata=0x1234_1234.
- Half load at 0x...0001 → d_gnt=1, d_err=1, m_en=0, no d_rvalid in the following 8 cycles.
- MEM_LAT=3, i_req and d_req both held from cycle 0:
  - Without macro: d_gnt c0, d_rvalid c3, i_gnt c3, i_rvalid c6.
  - With XGRISCV_ARB_RR_EN and last=data: i_gnt c0 first.
- MEM_LAT=3, grant at c0, reset low at c1 → i_rvalid/d_rvalid remain 0 through c4. After release, a fresh fetch completes normally with cnt starting at 0.
